regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (rd_addr/rd_data/rd_wren) between
//  NUM_REQ writeback requesters, e.g. ALU, load unit and CSR unit.
//  - Per-requester valid/ready handshake; one grant per cycle.
//  - Registered write-port outputs feed the register file directly.
//  - Saturating conflict counter provides performance visibility.

---
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the register file write port among NUM_REQ units.
// Define WB_RR_ARB_EN for round-robin; default build is fixed priority.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [5*NUM_REQ-1:0]  i_req_addr,
  input  logic [32*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [4:0]            o_rd_addr,
  output logic [31:0]           o_rd_data,
  output logic                  o_rd_wren,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_conflict_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic          gnt_any;
  logic [PW-1:0] gnt_idx;

`ifdef WB_RR_ARB_EN
  logic [PW-1:0] ptr_q, ptr_d;

  // Scan downward so the last hit is the one closest to the pointer.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_idx == PW'(NUM_REQ - 1)) ptr_d = '0;
      else                             ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end
`endif

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++)
      o_req_ready[k] = !i_rst && gnt_any && (gnt_idx == PW'(k));
  end

  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == PW'(k)) begin
        sel_addr = i_req_addr[5*k +: 5];
        sel_data = i_req_data[32*k +: 32];
      end
    end
  end

  logic             wren_q, wren_d;
  logic [4:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // An x0 grant is consumed but issues no write; addr still lands at 0.
  always_comb begin
    wren_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (gnt_any) begin
      wren_d = (sel_addr != 5'd0);
      addr_d = sel_addr;
      data_d = sel_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ($countones(i_req_valid) >= 2 && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wren_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      wren_q <= wren_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_rd_wren      = wren_q;
  assign o_busy         = wren_q;
  assign o_rd_addr      = addr_q;
  assign o_rd_data      = data_q;
  assign o_conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus corner sequences.
// Expected grant order follows WB_RR_ARB_EN when defined.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  valid;
  logic [14:0] addr;
  logic [95:0] data;
  logic [2:0]  rdy;
  logic [4:0]  oaddr;
  logic [31:0] odata;
  logic        wren;
  logic        busy;
  logic [15:0] cnt;
  logic [2:0]  rdy4;
  logic [4:0]  oaddr4;
  logic [31:0] odata4;
  logic        wren4;
  logic        busy4;
  logic [3:0]  cnt4;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32];

  regfile_wb_arbiter #(.NUM_REQ(3), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(valid), .i_req_addr(addr), .i_req_data(data),
    .o_req_ready(rdy), .o_rd_addr(oaddr), .o_rd_data(odata),
    .o_rd_wren(wren), .o_busy(busy), .o_conflict_cnt(cnt)
  );

  regfile_wb_arbiter #(.NUM_REQ(3), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(valid), .i_req_addr(addr), .i_req_data(data),
    .o_req_ready(rdy4), .o_rd_addr(oaddr4), .o_rd_data(odata4),
    .o_rd_wren(wren4), .o_busy(busy4), .o_conflict_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wren) rf[oaddr] <= odata;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    valid = '0;
    rst   = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  rdy;
    logic        wren;
    logic [4:0]  oaddr;
    logic [31:0] odata;
    logic        chk_data;
  } vec_t;

  vec_t tbl [7];
  int   exp_k;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    tbl[0] = '{3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
               3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1};
    tbl[1] = '{3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234},
               3'b001, 1'b0, 5'd0, 32'h0, 1'b0};
    tbl[2] = '{3'b000, {5'd9, 5'd9, 5'd9}, {32'h5, 32'h5, 32'h5},
               3'b000, 1'b0, 5'd0, 32'h1234, 1'b1};
    tbl[3] = '{3'b100, {5'd31, 5'd0, 5'd0}, {32'hFFFFFFFF, 32'h0, 32'h0},
               3'b100, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
    tbl[4] = '{3'b000, {5'd4, 5'd4, 5'd4}, {32'h9, 32'h9, 32'h9},
               3'b000, 1'b0, 5'd31, 32'hFFFFFFFF, 1'b1};
    tbl[5] = '{3'b001, {5'd0, 5'd0, 5'd1}, {32'h0, 32'h0, 32'h1},
               3'b001, 1'b1, 5'd1, 32'h1, 1'b1};
    tbl[6] = '{3'b010, {5'd0, 5'd12, 5'd0}, {32'h0, 32'hA5A5A5A5, 32'h0},
               3'b010, 1'b1, 5'd12, 32'hA5A5A5A5, 1'b1};

    // Reset state, with valid high to confirm ready is gated.
    rst   = 1'b1;
    valid = 3'b111;
    addr  = {5'd3, 5'd2, 5'd1};
    data  = '0;
    #1;
    chk("rst_ready", 32'(rdy), 32'h0);
    chk("rst_wren", 32'(wren), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr", 32'(oaddr), 32'h0);
    chk("rst_data", odata, 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      valid = tbl[i].valid;
      addr  = tbl[i].addr;
      data  = tbl[i].data;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_wren", i), 32'(wren), 32'(tbl[i].wren));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].wren));
      chk($sformatf("vec%0d_addr", i), 32'(oaddr), 32'(tbl[i].oaddr));
      if (tbl[i].chk_data)
        chk($sformatf("vec%0d_data", i), odata, tbl[i].odata);
    end
    chk("vec_cnt", 32'(cnt), 32'h0);

    // Mid-stream reset drops the write in flight.
    valid = 3'b001;
    addr  = {5'd0, 5'd0, 5'd3};
    data  = {32'h0, 32'h0, 32'h77};
    #1;
    chk("mrst_pre_ready", 32'(rdy), 32'h1);
    @(posedge clk);
    #1;
    chk("mrst_pre_wren", 32'(wren), 32'h1);
    rst = 1'b1;
    #1;
    chk("mrst_wren", 32'(wren), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_addr", 32'(oaddr), 32'h0);
    chk("mrst_data", odata, 32'h0);
    chk("mrst_ready", 32'(rdy), 32'h0);
    @(posedge clk);
    #1;
    chk("mrst_hold_ready", 32'(rdy), 32'h0);
    chk("mrst_hold_wren", 32'(wren), 32'h0);
    rst   = 1'b0;
    valid = '0;

    // Arbitration under continuous contention.
    do_reset();
    valid = 3'b111;
    addr  = {5'd3, 5'd2, 5'd1};
    data  = {32'h102, 32'h101, 32'h100};
    for (int c = 0; c < 6; c++) begin
`ifdef WB_RR_ARB_EN
      exp_k = c % 3;
`else
      exp_k = 0;
`endif
      #1;
      chk($sformatf("arb%0d_ready", c), 32'(rdy), 32'(1 << exp_k));
      @(posedge clk);
      #1;
      chk($sformatf("arb%0d_addr", c), 32'(oaddr), 32'(exp_k + 1));
      chk($sformatf("arb%0d_data", c), odata, 32'h100 + 32'(exp_k));
      chk($sformatf("arb%0d_wren", c), 32'(wren), 32'h1);
    end
    valid = '0;
    chk("arb_cnt", 32'(cnt), 32'd6);

    // Same-address conflict serializes, last grant persists.
    do_reset();
    valid = 3'b101;
    addr  = {5'd7, 5'd0, 5'd7};
    data  = {32'hB, 32'h0, 32'hA};
    #1;
    chk("same_ready0", 32'(rdy), 32'b001);
    @(posedge clk);
    #1;
    chk("same_w0_data", odata, 32'hA);
    chk("same_w0_addr", 32'(oaddr), 32'd7);
    chk("same_w0_wren", 32'(wren), 32'h1);
    valid = 3'b100;
    #1;
    chk("same_ready2", 32'(rdy), 32'b100);
    @(posedge clk);
    #1;
    chk("same_w1_data", odata, 32'hB);
    chk("same_w1_addr", 32'(oaddr), 32'd7);
    chk("same_w1_wren", 32'(wren), 32'h1);
    valid = '0;
    @(posedge clk);
    #1;
    chk("same_rf7", rf[7], 32'hB);
    chk("same_cnt", 32'(cnt), 32'd1);
    chk("same_idle_wren", 32'(wren), 32'h0);

    // Counter saturation on the narrow instance.
    do_reset();
    valid = 3'b011;
    addr  = {5'd0, 5'd2, 5'd1};
    data  = {32'h0, 32'h22, 32'h11};
    repeat (20) @(posedge clk);
    #1 valid = '0;
    chk("sat_cnt16", 32'(cnt), 32'd20);
    chk("sat_cnt4", 32'(cnt4), 32'd15);
    @(posedge clk);
    #1;
    chk("sat_cnt4_hold", 32'(cnt4), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
